// File: rtl/spi_xact_arb.sv
// rtl/spi_xact_arb.sv - arbiter sharing one SPI_mnrch engine between inertial (req0) and A2D (req1) clients
module spi_xact_arb #(
    parameter int STARVE_LIM  = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter bit fast_sim    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] cmd0,
    input  logic        req1,
    input  logic [15:0] cmd1,
    output logic        done0,
    output logic [15:0] resp0,
    output logic        done1,
    output logic [15:0] resp1,
    output logic        m_snd,
    output logic [15:0] m_cmd,
    input  logic        m_done,
    input  logic [15:0] m_resp,
    input  logic        m_SS_n,
    output logic        SS0_n,
    output logic        SS1_n,
    output logic        to_err
);
    localparam int CW     = $clog2(TIMEOUT_CYC) + 1;
    localparam int TO_EFF = fast_sim ? 64 : TIMEOUT_CYC;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_EFF - 1);
    localparam int SW     = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RECOV} state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   m_cmd_q, m_cmd_d;
    logic          m_snd_q, m_snd_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [15:0]   resp0_q, resp0_d;
    logic [15:0]   resp1_q, resp1_d;
    logic          to_err_q, to_err_d;
    logic          force1;
    logic          gnt_pick;
    logic          ss_active;

    // req1 wins when req0 is absent or when req0 has won STARVE_LIM times in a row over it
    assign force1   = (starve_q == STARVE_MAX) & req1;
    assign gnt_pick = force1 | (req1 & ~req0);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        starve_d = starve_q;
        cnt_d    = cnt_q;
        m_cmd_d  = m_cmd_q;
        m_snd_d  = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        resp0_d  = resp0_q;
        resp1_d  = resp1_q;
        to_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    gnt_d   = gnt_pick;
                    m_cmd_d = gnt_pick ? cmd1 : cmd0;
                    m_snd_d = 1'b1;
                    state_d = LAUNCH;
                    if (gnt_pick || !req1) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                // completion takes precedence over a same-cycle timeout
                if (m_done || cnt_q == TO_LAST) begin
                    to_err_d = ~m_done;
                    if (gnt_q) begin
                        done1_d = 1'b1;
                        resp1_d = m_done ? m_resp : 16'h0000;
                    end else begin
                        done0_d = 1'b1;
                        resp0_d = m_done ? m_resp : 16'h0000;
                    end
                    state_d = RECOV;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RECOV: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            starve_q <= '0;
            cnt_q    <= '0;
            m_cmd_q  <= 16'h0000;
            m_snd_q  <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            resp0_q  <= 16'h0000;
            resp1_q  <= 16'h0000;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            starve_q <= starve_d;
            cnt_q    <= cnt_d;
            m_cmd_q  <= m_cmd_d;
            m_snd_q  <= m_snd_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            resp0_q  <= resp0_d;
            resp1_q  <= resp1_d;
            to_err_q <= to_err_d;
        end
    end

    assign ss_active = (state_q == LAUNCH) || (state_q == BUSY);
    assign SS0_n     = (ss_active && !gnt_q) ? m_SS_n : 1'b1;
    assign SS1_n     = (ss_active &&  gnt_q) ? m_SS_n : 1'b1;

    assign m_snd  = m_snd_q;
    assign m_cmd  = m_cmd_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign resp0  = resp0_q;
    assign resp1  = resp1_q;
    assign to_err = to_err_q;
endmodule

// File: tb/tb_spi_xact_arb.sv
// tb/tb_spi_xact_arb.sv - scoreboard bench for spi_xact_arb with an SPI_mnrch stand-in
module tb_spi_xact_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] cmd0, cmd1;
    logic        done0, done1;
    logic [15:0] resp0, resp1;
    logic        m_snd;
    logic [15:0] m_cmd;
    logic        m_done;
    logic [15:0] m_resp;
    logic        m_SS_n;
    logic        SS0_n, SS1_n;
    logic        to_err;

    typedef struct {
        logic        port;
        logic [15:0] resp;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    int          vecs = 0;
    int          errs = 0;
    int          cyc = 0;
    int          snd_cnt = 0;
    int          snd_at;
    int          last_wait;
    logic [15:0] resp0_m = 16'h0000;
    logic [15:0] resp1_m = 16'h0000;

    spi_xact_arb #(.STARVE_LIM(4), .TIMEOUT_CYC(1024), .fast_sim(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
        .done0(done0), .resp0(resp0), .done1(done1), .resp1(resp1),
        .m_snd(m_snd), .m_cmd(m_cmd), .m_done(m_done), .m_resp(m_resp),
        .m_SS_n(m_SS_n), .SS0_n(SS0_n), .SS1_n(SS1_n), .to_err(to_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $error("FAIL watchdog sim time exceeded, bench did not finish");
        $fatal(1);
    end

    always @(negedge clk) if (m_snd) snd_cnt++;

    // pop expected completions as done pulses appear
    always @(negedge clk) begin
        if (rst_n && (done0 || done1)) begin
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $error("FAIL unexpected_done done0=%b done1=%b expected none", done0, done1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                vecs += 2;
                assert ({done1, done0} === (e.port ? 2'b10 : 2'b01)) else begin
                    errs++;
                    $error("FAIL done_port observed=%b expected port %0d", {done1, done0}, e.port);
                end
                assert ((e.port ? resp1 : resp0) === e.resp) else begin
                    errs++;
                    $error("FAIL resp observed=%h expected=%h", e.port ? resp1 : resp0, e.resp);
                end
                assert (to_err === e.to) else begin
                    errs++;
                    $error("FAIL to_err observed=%b expected=%b", to_err, e.to);
                end
            end
        end
    end

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic push(input logic port, input logic [15:0] rsp, input logic to);
        exp_t e;
        e.port = port;
        e.resp = rsp;
        e.to   = to;
        exp_q.push_back(e);
        if (port) resp1_m = rsp;
        else      resp0_m = rsp;
    endtask

    // lat >= 0: m_done after lat BUSY cycles; lat < 0: never answer (watchdog path)
    task automatic serve(input logic port, input logic [15:0] cmd, input int lat, input logic [15:0] rsp);
        int n;
        n = 0;
        while (m_snd !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        snd_at    = cyc;
        chk1("m_snd_seen", m_snd, 1'b1);
        chk16("m_cmd", m_cmd, cmd);
        @(negedge clk);
        m_SS_n = 1'b0;
        #1;
        chk1("ss_granted", port ? SS1_n : SS0_n, 1'b0);
        chk1("ss_other", port ? SS0_n : SS1_n, 1'b1);
        if (lat >= 0) begin
            repeat (lat) @(negedge clk);
            m_SS_n = 1'b1;
            m_done = 1'b1;
            m_resp = rsp;
            push(port, rsp, 1'b0);
            @(negedge clk);
            m_done = 1'b0;
        end else begin
            push(port, 16'h0000, 1'b1);
            n = 0;
            while (!(done0 || done1) && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk16("timeout_latency", n[15:0], 16'd64);
            m_SS_n = 1'b1;
        end
    endtask

    initial begin
        int s1;
        logic [4:0] order;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; cmd0 = 16'h0; cmd1 = 16'h0;
        m_done = 1'b0; m_resp = 16'h0; m_SS_n = 1'b1;
        repeat (3) @(negedge clk);
        chk1("rst_m_snd", m_snd, 1'b0);
        chk16("rst_m_cmd", m_cmd, 16'h0000);
        chk16("rst_resp0", resp0, 16'h0000);
        chk16("rst_resp1", resp1, 16'h0000);
        chk1("rst_done0", done0, 1'b0);
        chk1("rst_done1", done1, 1'b0);
        chk1("rst_to_err", to_err, 1'b0);
        chk1("rst_ss0", SS0_n, 1'b1);
        chk1("rst_ss1", SS1_n, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1) single inertial transaction
        req0 = 1'b1; cmd0 = 16'hA2C5;
        serve(1'b0, 16'hA2C5, 40, 16'h1234);
        chk16("req_to_snd_latency", last_wait[15:0], 16'd1);
        req0 = 1'b0;
        @(negedge clk);
        chk1("done0_one_cycle", done0, 1'b0);
        chk16("resp0_hold", resp0, resp0_m);
        chk16("snd_count", snd_cnt[15:0], 16'd1);

        // 2) simultaneous requests: req0 first, req1 after 4 + SPI cycles
        req0 = 1'b1; cmd0 = 16'h0A01; req1 = 1'b1; cmd1 = 16'h1B02;
        serve(1'b0, 16'h0A01, 10, 16'h5555);
        s1 = snd_at;
        req0 = 1'b0;
        serve(1'b1, 16'h1B02, 5, 16'hAAAA);
        chk16("snd_spacing", 16'(snd_at - s1), 16'd14);
        req1 = 1'b0;
        @(negedge clk);

        // 3) starvation guard: both held, order 0,0,0,0,1 twice
        req0 = 1'b1; cmd0 = 16'h3000; req1 = 1'b1; cmd1 = 16'h3111;
        order = 5'b10000;
        for (int i = 0; i < 10; i++) begin
            logic p;
            p = order[i % 5];
            serve(p, p ? 16'h3111 : 16'h3000, 2, 16'h7000 + 16'(i));
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // 4) watchdog abort, then normal recovery
        req0 = 1'b1; cmd0 = 16'h4444;
        serve(1'b0, 16'h4444, -1, 16'h0000);
        req0 = 1'b0;
        @(negedge clk);
        chk1("to_err_one_cycle", to_err, 1'b0);
        req0 = 1'b1; cmd0 = 16'h4445;
        serve(1'b0, 16'h4445, 3, 16'hBEEF);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        // 5) stray m_done in IDLE, then m_done on the timeout cycle
        m_done = 1'b1; m_resp = 16'hDEAD;
        @(negedge clk);
        m_done = 1'b0;
        chk1("stray_done0", done0, 1'b0);
        chk1("stray_done1", done1, 1'b0);
        chk16("stray_resp0", resp0, resp0_m);
        chk16("stray_resp1", resp1, resp1_m);
        req1 = 1'b1; cmd1 = 16'h5151;
        serve(1'b1, 16'h5151, 63, 16'h5A5A);
        req1 = 1'b0;
        repeat (2) @(negedge clk);

        // 6) reset while BUSY
        req0 = 1'b1; cmd0 = 16'h6666;
        repeat (3) @(negedge clk);
        m_SS_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; m_done = 1'b1; m_resp = 16'h9999;
        @(negedge clk);
        m_done = 1'b0; req0 = 1'b0;
        resp0_m = 16'h0000; resp1_m = 16'h0000;
        chk1("busy_rst_m_snd", m_snd, 1'b0);
        chk16("busy_rst_m_cmd", m_cmd, 16'h0000);
        chk16("busy_rst_resp0", resp0, resp0_m);
        chk16("busy_rst_resp1", resp1, resp1_m);
        chk1("busy_rst_done0", done0, 1'b0);
        chk1("busy_rst_done1", done1, 1'b0);
        chk1("busy_rst_to_err", to_err, 1'b0);
        chk1("busy_rst_ss0", SS0_n, 1'b1);
        chk1("busy_rst_ss1", SS1_n, 1'b1);
        rst_n = 1'b1; m_SS_n = 1'b1;
        repeat (4) @(negedge clk);
        chk16("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
